// File: rtl/adder_pipe_param.sv
// adder_pipe_param: chunked, pipelined add/sub with valid/ready flow control.
// Layer 0 registers the operands, with the subtrahend already inverted and the
// chunk-0 carry resolved. Each later layer adds one CW-bit chunk using the
// carry from the layer before it. Operand chunks ride along unchanged until
// their layer adds them (skew), and finished sum chunks ride along to the
// output (deskew), so sum/cout/overflow of a transaction leave together.
// The whole pipeline holds while a valid result waits for out_ready.
// Optional macro ADDER_PIPE_SAT_EN enables signed saturation driven by sat.
module adder_pipe_param #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    input  logic [1:0]       op,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = WIDTH / STAGES;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBB = 2'b11
    } op_e;

    // Layer k holds the transaction that has had chunks 0..k-1 added.
    logic             v_q [0:STAGES];
    logic             c_q [0:STAGES];
    logic [WIDTH-1:0] a_q [0:STAGES];
    logic [WIDTH-1:0] b_q [0:STAGES];
    logic [WIDTH-1:0] r_q [0:STAGES];
`ifdef ADDER_PIPE_SAT_EN
    logic             sat_q [0:STAGES];
`endif

    logic [CW:0]      part_c [0:STAGES-1];
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic             stall;
    logic             unused_bits;

    // Flow control: the pipeline holds only while a valid result is refused.
    always_comb begin
        stall    = v_q[STAGES] & ~out_ready;
        in_ready = ~stall;
    end

    // Operand conditioning: invert in2 for the subtracting modes, pick carry-in.
    always_comb begin
        b_eff = in2;
        c_eff = 1'b0;
        unique case (op_e'(op))
            OP_ADD: begin b_eff = in2;  c_eff = 1'b0; end
            OP_SUB: begin b_eff = ~in2; c_eff = 1'b1; end
            OP_ADC: begin b_eff = in2;  c_eff = cin;  end
            OP_SBB: begin b_eff = ~in2; c_eff = cin;  end
            default: begin b_eff = in2; c_eff = 1'b0; end
        endcase
    end

    // Per-layer chunk adders: layer k adds chunk k with the carry it holds.
    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            part_c[k] = {1'b0, a_q[k][k*CW +: CW]}
                      + {1'b0, b_q[k][k*CW +: CW]}
                      + {{CW{1'b0}}, c_q[k]};
        end
    end

    // Pipeline registers: load layer 0 from the inputs, advance every layer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k <= STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
`ifdef ADDER_PIPE_SAT_EN
                sat_q[k] <= 1'b0;
`endif
            end
        end else if (!stall) begin
            v_q[0] <= in_valid;
            c_q[0] <= c_eff;
            a_q[0] <= in1;
            b_q[0] <= b_eff;
            r_q[0] <= '0;
`ifdef ADDER_PIPE_SAT_EN
            sat_q[0] <= sat;
`endif
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k+1] <= v_q[k];
                c_q[k+1] <= part_c[k][CW];
                a_q[k+1] <= a_q[k];
                b_q[k+1] <= b_q[k];
                r_q[k+1] <= r_q[k];
                r_q[k+1][k*CW +: CW] <= part_c[k][CW-1:0];
`ifdef ADDER_PIPE_SAT_EN
                sat_q[k+1] <= sat_q[k];
`endif
            end
        end
    end

    // Output stage: flags from the unsaturated result, optional clamp on sum.
    always_comb begin
        out_valid = v_q[STAGES];
        cout      = c_q[STAGES];
        overflow  = (a_q[STAGES][WIDTH-1] == b_q[STAGES][WIDTH-1]) &&
                    (r_q[STAGES][WIDTH-1] != a_q[STAGES][WIDTH-1]);
        sum       = r_q[STAGES];
`ifdef ADDER_PIPE_SAT_EN
        if (sat_q[STAGES] && overflow) begin
            sum = a_q[STAGES][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Sink for bits that are intentionally not consumed in this configuration.
    always_comb begin
`ifdef ADDER_PIPE_SAT_EN
        unused_bits = ^{a_q[STAGES], b_q[STAGES]};
`else
        unused_bits = ^{a_q[STAGES], b_q[STAGES], sat};
`endif
    end

endmodule

// File: tb/tb_adder_pipe_param.sv
// Bench for adder_pipe_param (WIDTH=32, STAGES=4): a queue-based transaction
// model plus directed vectors with hand-computed results.
module tb_adder_pipe_param;

    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         cin = 1'b0;
    logic [1:0]   op = 2'b00;
    logic         sat = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int errors = 0;
    int checks = 0;
    int n_in = 0;
    int n_out = 0;
    int ir_low = 0;

    bit           lit_en = 1'b0;
    logic [W-1:0] lit_s = '0;
    logic         lit_c = 1'b0;
    logic         lit_o = 1'b0;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int unsigned  age;
        bit           lit;
        logic [W-1:0] ls;
        logic         lc;
        logic         lo;
    } ent_t;

    ent_t q[$];

    always #5 clk = ~clk;

    adder_pipe_param #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .cin(cin), .op(op), .sat(sat),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic meaning of one transaction.
    function automatic ent_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [1:0] o, input logic c, input logic s);
        ent_t         e;
        logic [W-1:0] bb;
        logic         ci;
        logic [W:0]   full;
        bb = o[0] ? ~b : b;
        ci = o[1] ? c : o[0];
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
        e.s = full[W-1:0];
        e.c = full[W];
        e.o = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
`ifdef ADDER_PIPE_SAT_EN
        if (s && e.o) e.s = a[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
        if (s && 1'b0) e.s = '0;
`endif
        e.age = 0;
        e.lit = 1'b0;
        e.ls = '0;
        e.lc = 1'b0;
        e.lo = 1'b0;
        return e;
    endfunction

    // Model timing: entries age on every edge the pipeline advances.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            bit stall_m;
            stall_m = (q.size() > 0) && (q[0].age == S) && !out_ready;
            if (!stall_m) begin
                if (q.size() > 0 && q[0].age == S) begin
                    void'(q.pop_front());
                    n_out++;
                end
                for (int i = 0; i < q.size(); i++) begin
                    ent_t t;
                    t = q[i];
                    t.age++;
                    q[i] = t;
                end
                if (in_valid) begin
                    ent_t e;
                    e = model(in1, in2, op, cin, sat);
                    e.lit = lit_en;
                    e.ls = lit_s;
                    e.lc = lit_c;
                    e.lo = lit_o;
                    q.push_back(e);
                    n_in++;
                end
            end
        end
    end

    // Compare DUT against the model every cycle.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_out_valid", W'(out_valid), '0);
            chk("rst_sum", sum, '0);
            chk("rst_cout", W'(cout), '0);
            chk("rst_overflow", W'(overflow), '0);
            chk("rst_in_ready", W'(in_ready), W'(1));
        end else begin
            bit exp_v;
            exp_v = (q.size() > 0) && (q[0].age == S);
            if (!in_ready) ir_low++;
            chk("out_valid", W'(out_valid), W'(exp_v));
            chk("in_ready", W'(in_ready), W'(!(exp_v && !out_ready)));
            if (exp_v) begin
                chk("sum", sum, q[0].s);
                chk("cout", W'(cout), W'(q[0].c));
                chk("overflow", W'(overflow), W'(q[0].o));
                if (q[0].lit) begin
                    chk("lit_model_sum", q[0].s, q[0].ls);
                    chk("lit_sum", sum, q[0].ls);
                    chk("lit_cout", W'(cout), W'(q[0].lc));
                    chk("lit_overflow", W'(overflow), W'(q[0].lo));
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] o,
                        input logic c, input logic s, input bit l,
                        input logic [W-1:0] ls, input logic lc, input logic lo);
        bit          took;
        int unsigned n;
        in1 = a; in2 = b; op = o; cin = c; sat = s;
        lit_en = l; lit_s = ls; lit_c = lc; lit_o = lo;
        in_valid = 1'b1;
        took = 1'b0;
        n = 0;
        while (!took && n < 50) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk("send_accept", W'(took), W'(1));
        in_valid = 1'b0;
        lit_en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", W'(q.size()), '0);
    endtask

    logic [W-1:0] sa [8] = '{32'h1234_5678, 32'hFFFF_0000, 32'h8000_0000, 32'h00FF_00FF,
                             32'hDEAD_BEEF, 32'h7FFF_FFFF, 32'h0000_0000, 32'hAAAA_AAAA};
    logic [W-1:0] sb [8] = '{32'h1111_1111, 32'h0001_0000, 32'h0000_0001, 32'hFF00_FF00,
                             32'hCAFE_BABE, 32'h7FFF_FFFF, 32'h0000_0000, 32'h5555_5555};
    logic [1:0]   so [8] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10};
    logic         sc [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic         ss [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        logic [W-1:0] sat_pos;
        logic [W-1:0] sat_neg;
        int sent;
`ifdef ADDER_PIPE_SAT_EN
        sat_pos = 32'h7FFF_FFFF;
        sat_neg = 32'h8000_0000;
`else
        sat_pos = 32'h8000_0000;
        sat_neg = 32'h7FFF_FFFF;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed vectors with hand-computed results.
        send(32'h0000_FFFF, 32'h0000_0001, 2'b00, 1'b0, 1'b0, 1, 32'h0001_0000, 1'b0, 1'b0);
        drain();
        send(32'h0000_FFFF, 32'h0000_0001, 2'b00, 1'b1, 1'b0, 1, 32'h0001_0000, 1'b0, 1'b0);
        send(32'd5,         32'd7,         2'b01, 1'b0, 1'b0, 1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 1'b0, 1'b0, 1, 32'h0000_0000, 1'b1, 1'b0);
        send(32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 1'b0, 1'b1, 1, sat_pos,       1'b0, 1'b1);
        send(32'h8000_0000, 32'h0000_0001, 2'b01, 1'b0, 1'b1, 1, sat_neg,       1'b1, 1'b1);
        send(32'h0000_0000, 32'h0000_0000, 2'b11, 1'b0, 1'b0, 1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        send(32'h0000_0000, 32'h0000_0000, 2'b10, 1'b1, 1'b0, 1, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h0000_0000, 32'h0000_0000, 2'b01, 1'b0, 1'b0, 1, 32'h0000_0000, 1'b1, 1'b0);
        drain();

        // Back-to-back stream of 8 with a 3-cycle downstream stall mid-stream.
        ir_low = 0;
        sent = n_in;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(sa[i], sb[i], so[i], sc[i], ss[i], 0, '0, 1'b0, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_in_ready_low_cycles", W'(ir_low), W'(3));
        chk("stream_accepted", W'(n_in - sent), W'(8));
        chk("delivered_count", W'(n_out), W'(n_in));

        // Reset with three transactions in flight, one of them at the output.
        out_ready = 1'b0;
        send(32'h0000_0010, 32'h0000_0020, 2'b00, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
        send(32'h0000_0030, 32'h0000_0040, 2'b00, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
        send(32'h0000_0050, 32'h0000_0060, 2'b00, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        chk("pre_reset_out_valid", W'(out_valid), W'(1));
        chk("pre_reset_sum", sum, 32'h0000_0030);
        rst = 1'b1;
        q.delete();
        #1;
        chk("async_rst_out_valid", W'(out_valid), '0);
        chk("async_rst_sum", sum, '0);
        chk("async_rst_in_ready", W'(in_ready), W'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_reset_no_stale", W'(q.size()), '0);

        // First transfer right after release works normally.
        send(32'h0000_0100, 32'h0000_0023, 2'b00, 1'b0, 1'b0, 1, 32'h0000_0123, 1'b0, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/adder_pipe_param.md
ADDER_PIPE_PARAM -- requirements
Module: adder_pipe_param

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter STAGES, default 4: pipeline depth; WIDTH SHALL be an integer multiple of STAGES; chunk width CW = WIDTH/STAGES.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 in1, in2  input  WIDTH  operands.
REQ-008 cin  input  1  carry/borrow-in for the chained modes.
REQ-009 op  input  2  00 add, 01 sub, 10 add-with-carry, 11 sub-with-borrow.
REQ-010 sat  input  1  signed saturation request; the port SHALL be present in both configurations.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry-out of the MSB.
REQ-015 overflow  output  1  signed overflow of the unsaturated result.

Function
REQ-016 Effective operation: op=00 gives in1+in2+0; op=01 gives in1+~in2+1; op=10 gives in1+in2+cin; op=11 gives in1+~in2+cin.
REQ-017 Stage k (0..STAGES-1) adds operand chunk k using the carry registered by stage k-1, with the chunk-0 carry taken from REQ-016.
REQ-018 Higher operand chunks SHALL be skew-delayed and completed lower sum chunks deskew-delayed, so that sum, cout and overflow for one transaction emerge together.
REQ-019 A transfer occurs on an edge where in_valid and in_ready are both 1.
REQ-020 stall = out_valid AND NOT out_ready; in_ready = NOT stall, computed combinationally.
REQ-021 When stall=1, every stage register and valid bit SHALL hold; when stall=0, the whole pipeline SHALL advance one stage.
REQ-022 Latency: a transfer at edge N SHALL raise out_valid after edge N+STAGES, plus one cycle for each stalled cycle in between.
REQ-023 Throughput SHALL be one result per cycle with no stalls; bubbles (in_valid=0) SHALL propagate as invalid slots.
REQ-024 On an edge where out_ready rises while stalled, the pipeline SHALL advance and SHALL accept a new input on that same edge.
REQ-025 overflow = (a_msb == b_msb) AND (sum_msb != a_msb), where b is the operand after the inversion of REQ-016.
REQ-026 STAGES=1 SHALL degenerate to a single registered adder with latency 1.
REQ-027 sum, cout and overflow are don't-care while out_valid=0.

Reset
REQ-028 While rst=1, all valid bits, sum, cout and overflow SHALL be 0 immediately and independent of clk.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight transactions.
REQ-030 in_ready SHALL be 1 while rst=1.
REQ-031 The first transfer is possible on the first edge after rst is released.

Configuration
REQ-032 Macro ADDER_PIPE_SAT_EN: when defined, a valid result with sat=1 and overflow=1 SHALL drive sum to 0x7FF..F if a_msb=0, or to 0x800..0 if a_msb=1.
REQ-033 Under ADDER_PIPE_SAT_EN, sat SHALL be carried through the pipeline alongside its transaction, and cout and overflow SHALL still reflect the unsaturated result.
REQ-034 Without ADDER_PIPE_SAT_EN, sat SHALL be ignored and sum SHALL always wrap modulo 2^WIDTH.

Verification (WIDTH=32, STAGES=4)
REQ-035 Add in1=0x0000FFFF, in2=0x00000001, op=00, out_ready=1 -> 4 cycles later: sum=0x00010000, cout=0, overflow=0 (tests the inter-chunk carry).
REQ-036 Sub in1=5, in2=7, op=01 -> sum=0xFFFFFFFE, cout=0, overflow=0; add in1=0xFFFFFFFF, in2=1 -> sum=0, cout=1.
REQ-037 Add in1=0x7FFFFFFF, in2=1, sat=1 -> overflow=1; sum=0x7FFFFFFF with ADDER_PIPE_SAT_EN, sum=0x80000000 without.
REQ-038 Back-to-back stream of 8 transactions with out_ready held 0 for 3 cycles mid-stream -> in_ready=0 exactly during the stall, all 8 results delivered in order, none lost or duplicated.
REQ-039 Sub-with-borrow op=11, in1=0, in2=0, cin=0 -> sum=0xFFFFFFFF, cout=0; op=10 with cin=1, in1=in2=0 -> sum=1.
REQ-040 Assert rst with 3 transactions in flight -> out_valid=0 at once, and no stale result appears after release.
